// File: rtl/ymux_rr_arbiter_if.sv
// Handshake bundle between the round-robin arbiter (master side) and its requesters/consumer (slave side).
// The lock signal exists only when ARB_LOCK_EN is defined.
interface ymux_rr_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int PW    = 3
);
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] in_data;
  logic               out_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [N-1:0]       gnt;
  logic [PW-1:0]      gnt_idx;
  logic [N-1:0]       done;
`ifdef ARB_LOCK_EN
  logic               lock;
`endif

  modport master (
    input  req,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data,
    output gnt,
    output gnt_idx,
    output done
`ifdef ARB_LOCK_EN
    ,
    input  lock
`endif
  );

  modport slave (
    output req,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  gnt,
    input  gnt_idx,
    input  done
`ifdef ARB_LOCK_EN
    ,
    output lock
`endif
  );
endinterface

// File: rtl/ymux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared WIDTH-bit mux; zero-bubble back-to-back grants.
// Optional burst lock (up to 16 beats) is enabled by defining ARB_LOCK_EN.
module ymux_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int PW    = 3
) (
  input  logic                clk,
  input  logic                reset,
  ymux_rr_arbiter_if.master   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q;
  logic [N-1:0]     gnt_q;
  logic [PW-1:0]    gnt_idx_q;
  logic [PW-1:0]    ptr_q;

  logic [WIDTH-1:0] slice [N];

  logic             busy;
  logic             complete;
  logic             abandon;
  logic             retain;
  logic             release_now;
  logic [PW-1:0]    ptr_adv;
  logic [PW-1:0]    pick_start;
  logic [N-1:0]     pick_req;
  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic [N-1:0]     win_onehot;
  logic [WIDTH-1:0] sel_data;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign slice[gi]      = bus.in_data[gi*WIDTH +: WIDTH];
      assign win_onehot[gi] = win_found & (win_idx == PW'(gi));
    end
  endgenerate

  assign busy     = (state_q == BUSY);
  assign complete = busy & bus.out_ready;
  // A grantee that lets go of req before being served forfeits its slot.
  assign abandon  = busy & ~bus.out_ready & ~(|(bus.req & gnt_q));
  assign ptr_adv  = (gnt_idx_q == PW'(N - 1)) ? '0 : gnt_idx_q + PW'(1);

`ifdef ARB_LOCK_EN
  logic [3:0] lock_cnt_q;
  // The 16th locked completion always releases, bounding the burst.
  assign retain = complete & bus.lock & (lock_cnt_q != 4'hF);
`else
  assign retain = 1'b0;
`endif

  assign release_now = (complete | abandon) & ~retain;

  // When leaving BUSY, the outgoing grantee is masked for this one edge only.
  assign pick_start = busy ? ptr_adv : ptr_q;
  assign pick_req   = busy ? (bus.req & ~gnt_q) : bus.req;

  always_comb begin : p_pick
    int t;
    t         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    // Scan from the farthest position back so the closest hit wins last.
    for (int i = N - 1; i >= 0; i--) begin
      t = int'(pick_start) + i;
      if (t >= N) begin
        t = t - N;
      end
      for (int k = 0; k < N; k++) begin
        if ((k == t) && pick_req[k]) begin
          win_found = 1'b1;
          win_idx   = PW'(k);
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (busy && (gnt_idx_q == PW'(k))) begin
        sel_data = slice[k];
      end
    end
  end

  assign bus.out_valid = busy;
  assign bus.out_data  = sel_data;
  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.done      = gnt_q & {N{complete}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      ptr_q      <= '0;
`ifdef ARB_LOCK_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q    <= BUSY;
            gnt_q      <= win_onehot;
            gnt_idx_q  <= win_idx;
`ifdef ARB_LOCK_EN
            lock_cnt_q <= '0;
`endif
          end
        end
        BUSY: begin
`ifdef ARB_LOCK_EN
          if (retain) begin
            lock_cnt_q <= lock_cnt_q + 4'd1;
          end
`endif
          if (release_now) begin
            ptr_q <= ptr_adv;
`ifdef ARB_LOCK_EN
            lock_cnt_q <= '0;
`endif
            if (win_found) begin
              state_q   <= BUSY;
              gnt_q     <= win_onehot;
              gnt_idx_q <= win_idx;
            end else begin
              state_q   <= IDLE;
              gnt_q     <= '0;
              gnt_idx_q <= '0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ymux_rr_arbiter.sv
// Directed bench for ymux_rr_arbiter: a cycle table on an N=4 instance plus hand sequences
// for N=3 abandon/wrap and, when ARB_LOCK_EN is defined, the 16-beat burst limit.
module tb_ymux_rr_arbiter;
  localparam int W = 32;
  localparam logic [31:0] D0 = 32'hC0DE0000;
  localparam logic [31:0] D1 = 32'h11111111;
  localparam logic [31:0] D2 = 32'hDEADBEEF;
  localparam logic [31:0] D3 = 32'h33333333;
  localparam logic [31:0] E0 = 32'hAAAA0000;
  localparam logic [31:0] E1 = 32'hBBBB1111;
  localparam logic [31:0] E2 = 32'hCCCC2222;

  logic clk = 1'b0;
  logic rst4;
  logic rst3;
  always #5 clk = ~clk;

  ymux_rr_arbiter_if #(.WIDTH(W), .N(4), .PW(3)) bus4();
  ymux_rr_arbiter_if #(.WIDTH(W), .N(3), .PW(2)) bus3();

  ymux_rr_arbiter #(.WIDTH(W), .N(4), .PW(3)) dut4 (
    .clk   (clk),
    .reset (rst4),
    .bus   (bus4.master)
  );

  ymux_rr_arbiter #(.WIDTH(W), .N(3), .PW(2)) dut3 (
    .clk   (clk),
    .reset (rst3),
    .bus   (bus3.master)
  );

  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic [3:0]  e_gnt;
    logic [2:0]  e_idx;
    logic        e_valid;
    logic [31:0] e_data;
    logic [3:0]  e_done;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Cycle table: inputs held during the cycle, outputs observed mid-cycle.
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 3'd0, 1'b1, D0,    4'b0001};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 3'd1, 1'b1, D1,    4'b0010};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 3'd2, 1'b1, D2,    4'b0100};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 3'd3, 1'b1, D3,    4'b1000};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 3'd0, 1'b1, D0,    4'b0001};
    vecs[5]  = '{4'b0010, 1'b0, 4'b0010, 3'd1, 1'b1, D1,    4'b0000};
    vecs[6]  = '{4'b0010, 1'b0, 4'b0010, 3'd1, 1'b1, D1,    4'b0000};
    vecs[7]  = '{4'b0010, 1'b0, 4'b0010, 3'd1, 1'b1, D1,    4'b0000};
    vecs[8]  = '{4'b0010, 1'b1, 4'b0010, 3'd1, 1'b1, D1,    4'b0010};
    vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 32'h0, 4'b0000};
    vecs[10] = '{4'b0100, 1'b1, 4'b0000, 3'd0, 1'b0, 32'h0, 4'b0000};
    vecs[11] = '{4'b0100, 1'b1, 4'b0100, 3'd2, 1'b1, D2,    4'b0100};
    vecs[12] = '{4'b0000, 1'b1, 4'b0000, 3'd0, 1'b0, 32'h0, 4'b0000};
    vecs[13] = '{4'b0011, 1'b0, 4'b0000, 3'd0, 1'b0, 32'h0, 4'b0000};
    vecs[14] = '{4'b0011, 1'b1, 4'b0001, 3'd0, 1'b1, D0,    4'b0001};
    vecs[15] = '{4'b0011, 1'b1, 4'b0010, 3'd1, 1'b1, D1,    4'b0010};
    vecs[16] = '{4'b0001, 1'b0, 4'b0001, 3'd0, 1'b1, D0,    4'b0000};
    vecs[17] = '{4'b1000, 1'b0, 4'b0001, 3'd0, 1'b1, D0,    4'b0000};
    vecs[18] = '{4'b1000, 1'b0, 4'b1000, 3'd3, 1'b1, D3,    4'b0000};
    vecs[19] = '{4'b0000, 1'b0, 4'b1000, 3'd3, 1'b1, D3,    4'b0000};
    vecs[20] = '{4'b0000, 1'b0, 4'b0000, 3'd0, 1'b0, 32'h0, 4'b0000};

    rst4 = 1'b1;
    rst3 = 1'b1;
    bus4.req       = 4'b1111;
    bus4.out_ready = 1'b0;
    bus4.in_data   = {D3, D2, D1, D0};
    bus3.req       = 3'b000;
    bus3.out_ready = 1'b0;
    bus3.in_data   = {E2, E1, E0};
`ifdef ARB_LOCK_EN
    bus4.lock = 1'b0;
    bus3.lock = 1'b0;
`endif

    // Reset held for two edges with every requester asking.
    repeat (2) next_cycle();
    check("reset_gnt",   32'(bus4.gnt),       32'h0);
    check("reset_valid", 32'(bus4.out_valid), 32'h0);
    check("reset_data",  bus4.out_data,       32'h0);
    check("reset_done",  32'(bus4.done),      32'h0);
    $display("reset gnt=%b valid=%b data=%h", bus4.gnt, bus4.out_valid, bus4.out_data);
    rst4 = 1'b0;
    next_cycle();

    for (int v = 0; v < NV; v++) begin
      bus4.req       = vecs[v].req;
      bus4.out_ready = vecs[v].rdy;
      #2;
      $display("vec %0d req=%b rdy=%b gnt=%b idx=%0d valid=%b data=%h done=%b",
               v, vecs[v].req, vecs[v].rdy, bus4.gnt, bus4.gnt_idx, bus4.out_valid,
               bus4.out_data, bus4.done);
      check($sformatf("vec%0d_gnt", v),   32'(bus4.gnt),       32'(vecs[v].e_gnt));
      check($sformatf("vec%0d_idx", v),   32'(bus4.gnt_idx),   32'(vecs[v].e_idx));
      check($sformatf("vec%0d_valid", v), 32'(bus4.out_valid), 32'(vecs[v].e_valid));
      check($sformatf("vec%0d_data", v),  bus4.out_data,       vecs[v].e_data);
      check($sformatf("vec%0d_done", v),  32'(bus4.done),      32'(vecs[v].e_done));
      next_cycle();
    end

    // N=3: requester 2 granted, then abandons; pointer must wrap to 0.
    rst3 = 1'b0;
    bus3.req = 3'b100;
    bus3.out_ready = 1'b0;
    #2;
    check("n3_idle_gnt", 32'(bus3.gnt), 32'h0);
    next_cycle();
    check("n3_g2_gnt",  32'(bus3.gnt),     32'h4);
    check("n3_g2_idx",  32'(bus3.gnt_idx), 32'h2);
    check("n3_g2_data", bus3.out_data,     E2);
    $display("n3 grant gnt=%b idx=%0d data=%h", bus3.gnt, bus3.gnt_idx, bus3.out_data);
    bus3.req = 3'b001;
    #2;
    check("n3_abandon_done", 32'(bus3.done), 32'h0);
    check("n3_abandon_gnt",  32'(bus3.gnt),  32'h4);
    next_cycle();
    bus3.out_ready = 1'b1;
    #2;
    check("n3_wrap_gnt",  32'(bus3.gnt),     32'h1);
    check("n3_wrap_idx",  32'(bus3.gnt_idx), 32'h0);
    check("n3_wrap_data", bus3.out_data,     E0);
    check("n3_wrap_done", 32'(bus3.done),    32'h1);
    $display("n3 wrap gnt=%b idx=%0d done=%b", bus3.gnt, bus3.gnt_idx, bus3.done);
    next_cycle();
    bus3.req = 3'b000;
    bus3.out_ready = 1'b0;
    #2;
    check("n3_end_valid", 32'(bus3.out_valid), 32'h0);
    next_cycle();

`ifdef ARB_LOCK_EN
    begin
      int ndone3;
      ndone3 = 0;
      bus4.req = 4'b1000;
      bus4.out_ready = 1'b0;
      next_cycle();
      check("lock_grant3", 32'(bus4.gnt), 32'h8);
      bus4.req = 4'b1001;
      bus4.lock = 1'b1;
      bus4.out_ready = 1'b1;
      for (int b = 0; b < 20; b++) begin
        #2;
        if (bus4.done[3]) ndone3++;
        $display("lock beat %0d gnt=%b done=%b", b, bus4.gnt, bus4.done);
        if (b == 15) check("lock_beat15_done", 32'(bus4.done), 32'h8);
        if (b == 16) check("lock_release_gnt", 32'(bus4.gnt), 32'h1);
        next_cycle();
      end
      check("lock_done3_count", 32'(ndone3), 32'd16);
      bus4.lock = 1'b0;
      bus4.req = 4'b0000;
      next_cycle();
      bus4.out_ready = 1'b0;
      #2;
      check("lock_end_valid", 32'(bus4.out_valid), 32'h0);
      next_cycle();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ymux_rr_arbiter.md
Name: ymux_rr_arbiter

Overview:
- Round-robin arbiter sharing one WIDTH-bit datapath output among N requesters.
- Drives the select of a yMux-style mux tree: the registered grant picks which requester's data reaches the shared bus.
- Sits between register-file or datapath sources and a single consumer, such as a memory write port or ALU operand bus.
- Uses a valid/ready handshake toward the consumer and a req/done handshake toward the requesters.

Parameters:
- WIDTH, 32, data width of each requester and of the output bus.
- N, 4, number of requesters; legal values 2..8.
- PW, 3, pointer/index width; must satisfy 2**PW >= N.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  N  per-requester request; bit k held high until done[k].
- in_data  input  N*WIDTH  flattened requester data; slice k is in_data[k*WIDTH +: WIDTH], stable while req[k] is high.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_valid  output  1  out_data holds a granted requester's data.
- out_data  output  WIDTH  muxed data of the granted requester; 0 when not valid.
- gnt  output  N  one-hot registered grant; all-zero when idle.
- gnt_idx  output  PW  binary index of the granted requester; 0 when idle.
- done  output  N  one-cycle pulse to the granted requester: gnt[k] & out_ready.
- lock  input  1  burst hold request from the current grantee; present only with ARB_LOCK_EN.

Behaviour:
- Reset (synchronous, at the clk edge where reset=1):
  - state=IDLE, gnt=0, gnt_idx=0, ptr=0, out_valid=0, out_data=0, done=0.
  - A reset mid-transfer drops the grant with no done pulse; the requester must re-request.
- States:
  - IDLE: out_valid=0.
    - If req!=0 at the clk edge: pick winner w = first set bit of req searching ptr, ptr+1, ... wrapping modulo N.
    - Register gnt=1<<w and gnt_idx=w; go to BUSY.
    - If req==0: stay in IDLE.
  - BUSY: out_valid=1; out_data=in_data slice gnt_idx (combinational from the registered select).
    - out_ready=0: hold gnt; out_data tracks the slice.
    - out_ready=1: done[gnt_idx]=1 combinationally this cycle. At the edge, ptr=(gnt_idx+1) mod N, then re-arbitrate immediately.
    - Re-arbitration excludes the completing requester's req bit for that one edge only.
    - If another request is pending, go straight to BUSY with the new grant (zero-bubble back-to-back). Otherwise go to IDLE with gnt=0.
- Latency:
  - Request to out_valid: 1 cycle.
  - Sustained throughput with out_ready=1 and multiple requesters: 1 transfer/cycle.
- Request rules:
  - A requester deasserts req the cycle after done.
  - If req stays high, a new request is seen from the next edge on, under normal round-robin order.
  - If the granted requester drops req before done, the arbiter abandons the grant at the next edge: no done, ptr advances, re-arbitrate.
- Fairness: at most N-1 other grants occur between two grants to the same continuously requesting input.
- Arithmetic:
  - Pointer wrap is modulo N, not 2**PW; for N=3, index 2 wraps to 0.
  - Unused gnt_idx codes are never produced.
- Simultaneous events: reset has priority over everything; out_ready while in IDLE is ignored.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - The lock port exists. While in BUSY, if lock=1 at a completing edge (out_ready=1), the grant is retained: gnt and ptr are unchanged, done still pulses, and state stays BUSY.
  - The grant is also retained while lock=1 and req[gnt_idx]=1 at any edge.
  - The grant releases at the first completing edge with lock=0.
  - Maximum burst is 16 beats; a 4-bit counter forces release on the 16th locked completion.
- Undefined: the lock port is absent and every grant is exactly one transfer.

Test Plan:
- Reset: hold reset=1 for 2 cycles with req=4'b1111 -> gnt=0, out_valid=0, out_data=0. After release, the first grant is gnt=4'b0001 on the next edge.
- Single request: req=4'b0100, in_data slice 2=32'hDEADBEEF, out_ready=1 -> one cycle later gnt=4'b0100, out_data=32'hDEADBEEF, done=4'b0100. The next cycle is IDLE once req is dropped.
- Round-robin: req=4'b1111 held (re-asserted after each done), out_ready=1 -> grant order 0,1,2,3,0 on consecutive cycles, with no bubble.
- Backpressure: grant to requester 1, out_ready=0 for 3 cycles -> gnt, out_valid and out_data are stable and done=0. On the 4th cycle out_ready=1 -> single done[1] pulse.
- Abandon and wrap: N=3, requester 2 granted, drops req before out_ready, req[0]=1 -> no done[2]; next grant is gnt=3'b001 (ptr wrapped 2->0).
- ARB_LOCK_EN: requester 3 granted with lock=1 for 20 beats and out_ready=1, req=4'b1001 -> 16 consecutive done[3] pulses, then a forced release to requester 0.
